blit_sequencer: RTL and testbench

Command-driven sequencer for the 2D blitter datapath. Accepts one rectangle-copy command at a time and walks the rectangle pixel by pixel: it reads each pixel from the sprite buffer and writes it to the pixel buffer at the stride-corrected destination address. It sits between the command source (CPU or display-list fetcher) and the two buffer ports. It owns the sprite read port and is the sole writer on its pixel-buffer write port.

---
 rtl/blit_sequencer.sv | 120 ++++++++++++
 tb/tb_blit_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/blit_sequencer.sv
// Rectangle-copy sequencer: READ/LATCH/WRITE per pixel (3 cycles, 2 if skipped), +1 DONE cycle; WRITE
// holds fb_addr/fb_data until fb_ready. Optional colour-key skip under BLIT_TRANSPARENCY_EN.
module blit_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int PIX_W    = 8,
  parameter int DIM_W    = 8,
  parameter int FB_WIDTH = 320
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DIM_W-1:0]  cmd_w,
  input  logic [DIM_W-1:0]  cmd_h,
  input  logic [PIX_W-1:0]  cmd_key,
  output logic              spr_rd,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [PIX_W-1:0]  spr_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [DIM_W-1:0]   w_q, h_q, col, row;
  logic [ADDR_W-1:0]  src_ptr, row_base;
  logic [PIX_W-1:0]   pix;
  logic               skip, last_col, last_pix, advance, empty_cmd;

`ifdef BLIT_TRANSPARENCY_EN
  logic [PIX_W-1:0]   key_q;
  assign skip = (spr_data == key_q);
`else
  logic unused_key;
  assign unused_key = ^cmd_key;
  assign skip = 1'b0;
`endif

  assign empty_cmd = (cmd_w == '0) || (cmd_h == '0);
  assign last_col  = (col == w_q - DIM_W'(1));
  assign last_pix  = last_col && (row == h_q - DIM_W'(1));
  assign advance   = ((state == WRITE) && fb_ready) || ((state == LATCH) && skip);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = empty_cmd ? DONE : READ;
      READ:    state_nxt = LATCH;
      LATCH:   if (skip) state_nxt = last_pix ? DONE : READ;
               else      state_nxt = WRITE;
      WRITE:   if (fb_ready) state_nxt = last_pix ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    spr_rd    = (state == READ);
    fb_we     = (state == WRITE);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Walk pointers; all address arithmetic wraps silently at 2^ADDR_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      src_ptr  <= '0;
      row_base <= '0;
      pix      <= '0;
`ifdef BLIT_TRANSPARENCY_EN
      key_q    <= '0;
`endif
    end else begin
      if (state == IDLE && cmd_valid) begin
        w_q      <= cmd_w;
        h_q      <= cmd_h;
        col      <= '0;
        row      <= '0;
        src_ptr  <= cmd_src;
        row_base <= cmd_dst;
`ifdef BLIT_TRANSPARENCY_EN
        key_q    <= cmd_key;
`endif
      end
      if (state == LATCH) pix <= spr_data;
      if (advance) begin
        src_ptr <= src_ptr + ADDR_W'(1);
        if (last_col) begin
          col      <= '0;
          row      <= row + DIM_W'(1);
          row_base <= row_base + ADDR_W'(FB_WIDTH);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
    end
  end

  assign spr_addr = src_ptr;
  assign fb_addr  = row_base + ADDR_W'(col);
  assign fb_data  = pix;

endmodule

// File: tb/tb_blit_sequencer.sv
// Scoreboarded bench: expected reads/writes queued per command, checked as the DUT issues them.
module tb_blit_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_src = '0, cmd_dst = '0;
  logic [7:0]  cmd_w = '0, cmd_h = '0, cmd_key = '0;
  logic        spr_rd;
  logic [15:0] spr_addr;
  logic [7:0]  spr_data = 8'hEE;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready = 1'b1;
  logic        busy, done;

  blit_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_key(cmd_key),
    .spr_rd(spr_rd), .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];

  int stall_idx_cfg = 0;
  int stall_len_cfg = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Sprite memory, access scoreboard and fb_ready stall generator.
  logic        spr_pend = 1'b0;
  logic [15:0] spr_pend_addr = '0;
  int          wr_count = 0;
  int          stall_left = 0;
  logic        hold_vld = 1'b0;
  logic [23:0] hold_val = '0;

  always @(negedge clock) begin
    logic [15:0] ea;
    logic [23:0] ew;
    spr_data      = spr_pend ? mem[spr_pend_addr] : 8'hEE;
    spr_pend      = spr_rd;
    spr_pend_addr = spr_addr;
    if (spr_rd) begin
      if (rd_q.size() == 0) chk("spr_rd_extra", 32'd1, 32'd0);
      else begin
        ea = rd_q.pop_front();
        chk("spr_addr", {16'd0, spr_addr}, {16'd0, ea});
      end
    end
    if (cmd_valid && cmd_ready) begin
      wr_count   = 0;
      stall_left = stall_len_cfg;
    end
    if (fb_we) begin
      if (wr_count + 1 == stall_idx_cfg && stall_left > 0) begin
        if (hold_vld) chk("stall_stable", {8'd0, fb_addr, fb_data}, {8'd0, hold_val});
        hold_vld   = 1'b1;
        hold_val   = {fb_addr, fb_data};
        fb_ready   = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        if (hold_vld) chk("stall_release", {8'd0, fb_addr, fb_data}, {8'd0, hold_val});
        hold_vld = 1'b0;
        fb_ready = 1'b1;
        wr_count = wr_count + 1;
        if (wr_q.size() == 0) chk("fb_we_extra", 32'd1, 32'd0);
        else begin
          ew = wr_q.pop_front();
          chk("fb_write", {8'd0, fb_addr, fb_data}, {8'd0, ew});
        end
      end
    end else begin
      fb_ready = 1'b1;
    end
  end

  // Queue the expected accesses of one command; returns the expected busy length.
  task automatic expect_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w,
                            input logic [7:0] h, input logic [7:0] key, input int stall_idx,
                            input int stall_len, output int exp_lat);
    int nwr, nskip;
    logic [15:0] a;
    logic [7:0]  d;
    logic        sk;
    nwr = 0; nskip = 0;
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        a = 16'(int'(src) + r * int'(w) + c);
        d = mem[a];
        rd_q.push_back(a);
`ifdef BLIT_TRANSPARENCY_EN
        sk = (d == key);
`else
        sk = 1'b0;
`endif
        if (sk) nskip++;
        else begin
          nwr++;
          wr_q.push_back({16'(int'(dst) + r * 320 + c), d});
        end
      end
    end
    exp_lat = 3 * nwr + 2 * nskip + 1;
    if (stall_idx > 0 && stall_idx <= nwr) exp_lat += stall_len;
  endtask

  task automatic issue(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w,
                       input logic [7:0] h, input logic [7:0] key);
    @(posedge clock); #1;
    cmd_src = src; cmd_dst = dst; cmd_w = w; cmd_h = h; cmd_key = key;
    cmd_valid = 1'b1;
    @(negedge clock);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_src = 16'($urandom); cmd_dst = 16'($urandom); cmd_w = 8'($urandom); cmd_h = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w,
                         input logic [7:0] h, input logic [7:0] key, input int stall_idx,
                         input int stall_len);
    int exp_lat, n, nbusy;
    stall_idx_cfg = stall_idx;
    stall_len_cfg = stall_len;
    expect_cmd(src, dst, w, h, key, stall_idx, stall_len, exp_lat);
    issue(src, dst, w, h, key);
    n = 0; nbusy = 0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      if (busy) nbusy++;
      if (done) break;
    end
    chk("done_latency", n, exp_lat);
    chk("busy_cycles", nbusy, exp_lat);
    @(negedge clock);
    chk("ready_after_done", {30'd0, cmd_ready, busy}, 32'd2);
    chk("reads_left", rd_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ctrl", {27'd0, cmd_ready, spr_rd, fb_we, busy, done}, 32'b10000);
    chk("rst_spr_addr", {16'd0, spr_addr}, 32'd0);
    chk("rst_fb", {8'd0, fb_addr, fb_data}, 32'd0);
  endtask

  initial begin
    int dummy, nwe;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
    mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h22;

    #12;
    chk_reset_vals();
    @(negedge clock);
    reset = 1'b1;

    run_cmd(16'h0100, 16'h0000, 8'd2, 8'd2, 8'hA5, 0, 0);
    run_cmd(16'h0300, 16'h1000, 8'd0, 8'd5, 8'hA5, 0, 0);
    run_cmd(16'h0400, 16'h2000, 8'd1, 8'd3, 8'hA5, 2, 4);
    run_cmd(16'h0200, 16'h3000, 8'd3, 8'd1, 8'h00, 0, 0);
    run_cmd(16'h0500, 16'hFFFF, 8'd2, 8'd1, 8'hA5, 0, 0);

    // Asynchronous reset in the middle of the second write of a 4x4 blit.
    stall_idx_cfg = 0; stall_len_cfg = 0;
    expect_cmd(16'h0600, 16'h4000, 8'd4, 8'd4, 8'hA5, 0, 0, dummy);
    issue(16'h0600, 16'h4000, 8'd4, 8'd4, 8'hA5);
    nwe = 0;
    for (int i = 0; i < 100 && nwe < 2; i++) begin
      @(negedge clock);
      if (fb_we) nwe++;
    end
    chk("reached_write", nwe, 2);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clock);
    chk_reset_vals();
    #2 reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_after_reset", {30'd0, cmd_ready, busy}, 32'd2);
    run_cmd(16'h0700, 16'h5000, 8'd3, 8'd2, 8'hA5, 0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [15:0] s;
      s = 16'($urandom);
      run_cmd(s, 16'($urandom), 8'($urandom_range(1, 4)), 8'($urandom_range(1, 3)), mem[s],
              (k % 2) ? 1 : 0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
